rx_ten_eight: RTL and testbench
===============================

Name: rx_ten_eight

Overview:
UART receive path that pairs with the 8-to-10 transmit path. Accepts serial 10-bit frames on rx_in: start bit 0, 8 data bits LSB first, stop bit 1. Bit timing comes from the same run-time baud value (clock cycles per bit) used by the transmitter. Outputs the recovered byte, the raw 10-bit frame, a one-cycle valid strobe and a one-cycle framing-error strobe.

Parameters:
SYNC_STAGES, 2, depth of the input synchronizer flop chain on rx_in (legal values 2..3).

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
en  input  1  receiver enable; 0 holds the FSM in IDLE
baud  input  20  clock cycles per bit; sampled continuously, must be stable during a frame
rx_in  input  1  serial line, asynchronous, idle high
dout  output  8  last received data byte
rx_d  output  10  last received raw frame, {stop, d7..d0, start}
rx_valid  output  1  one-cycle pulse, good frame received
frame_err  output  1  one-cycle pulse, stop bit sampled as 0
rx_busy  output  1  high in START, DATA and STOP states

Behaviour:
- Reset: state=IDLE, baud counter=0, bit index=0, shift register=0, synchronizer flops=1. Outputs: dout=0, rx_d=0, rx_valid=0, frame_err=0, rx_busy=0.
- Synchronizer: rx_in passes through SYNC_STAGES flops to give rx_s. All decisions below use rx_s.
- half = baud>>1. The counter is 20 bits, increments every cycle outside IDLE, and clears on every state change and on every bit sample.
- IDLE:
  - If en=1, baud>=4 and rx_s=0, go to START with cnt=0.
  - If en=0 or baud<4, stay in IDLE.
- START:
  - At cnt==half, if the sample is 0, go to DATA with cnt=0 and bit index=0.
  - If the sample is 1, treat it as a false start and return to IDLE. No strobes.
- DATA:
  - At cnt==baud-1, shift the sample into the MSB of the shift register (right shift, so the byte is LSB first) and increment the bit index.
  - After the 8th sample, go to STOP with cnt=0.
- STOP, at cnt==baud-1:
  - Sample 1: update dout and rx_d, pulse rx_valid.
  - Sample 0: update rx_d only (dout unchanged), pulse frame_err.
  - In both cases go to IDLE.
- Strobes are registered and high for exactly one cycle. rx_valid and frame_err are never high together.
- Latency: edge 0 is the first clock edge at which the first synchronizer flop captures rx_in=0. The strobe goes high after edge SYNC_STAGES + half + 9*baud.
- Back-to-back frames: IDLE is re-entered on the cycle after the stop sample, so a start bit arriving half a bit after the stop sample is detected.
- en deasserted mid-frame: abort to IDLE on the next edge, with no strobe. dout and rx_d keep their values.
- rst mid-frame: full reset as above on the next edge.
- Line held low (break): the frame completes with a frame_err pulse. The FSM then restarts only after rx_s has been seen 1 in IDLE.

Optional Feature:
RX_MAJORITY_EN
- Defined: every bit decision (start check, data bits, stop bit) is the majority of 3 consecutive rx_s values.
  - The samples are taken at counts N-2, N-1 and N, where N is the decision count (half or baud-1).
  - The decision is made on the same cycle as without the macro, so latency is identical.
  - A single-cycle glitch on rx_in never alters a decoded bit.
- Undefined: single sample of rx_s at count N. No extra flops.

Test Plan:
- Good frame: baud=8, rst released, rx_in frame for byte 0xA5 -> rx_valid pulses once after edge 2+4+72=78; dout=0xA5; rx_d=10'h34A; frame_err stays 0.
- Framing error: baud=8, byte 0x3C sent with stop bit 0 -> frame_err pulses once; rx_d=10'h078; dout keeps its previous value; no rx_valid.
- False start: baud=16, rx_in low for 3 cycles then high -> rx_busy rises, then falls at the half-bit check; no strobes; the next valid frame 0x55 decodes to dout=0x55.
- Back-to-back: baud=10, bytes 0x00 and 0xFF sent with no idle gap -> two rx_valid pulses 100 cycles apart; dout=0x00 then 0xFF.
- Reset/enable abort: baud=8, rst=1 for one cycle at bit 4 of a frame -> all outputs 0 on the next cycle and FSM in IDLE. Repeat with en=0 instead of rst -> FSM in IDLE, no strobe, dout unchanged.
- Glitch, RX_MAJORITY_EN defined: baud=16, byte 0xF0 with a 1-cycle low pulse on rx_in at the data bit-5 sample point -> dout=0xF0. With the macro undefined, the same stimulus gives dout=0xD0.

Source files
------------

// File: rtl/rx_ten_eight_if.sv
// rx_ten_eight_if - signal bundle for the rx_ten_eight UART receiver.
//
// Signals:
//   en        receiver enable (0 holds the receiver idle)
//   baud      clock cycles per bit, 20 bits
//   rx_in     asynchronous serial line, idle high
//   dout      last received data byte
//   rx_d      last received raw frame {stop, d7..d0, start}
//   rx_valid  one-cycle pulse, good frame received
//   frame_err one-cycle pulse, stop bit sampled as 0
//   rx_busy   high while a frame is being received
//
// Modports:
//   master  drives en/baud/rx_in, observes the receiver outputs
//   slave   the receiver itself
interface rx_ten_eight_if;
    logic        en;
    logic [19:0] baud;
    logic        rx_in;
    logic [7:0]  dout;
    logic [9:0]  rx_d;
    logic        rx_valid;
    logic        frame_err;
    logic        rx_busy;

    modport master (
        output en, baud, rx_in,
        input  dout, rx_d, rx_valid, frame_err, rx_busy
    );

    modport slave (
        input  en, baud, rx_in,
        output dout, rx_d, rx_valid, frame_err, rx_busy
    );
endinterface

// File: rtl/rx_ten_eight.sv
// rx_ten_eight - UART receive path for 10-bit frames
// (start 0, 8 data bits LSB first, stop 1), bit time set at run time by baud.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   rx_ten_eight_if.slave: en, baud, rx_in in; dout, rx_d,
//         rx_valid, frame_err, rx_busy out
//
// Parameters:
//   SYNC_STAGES  depth of the rx_in synchronizer chain (2..3)
//
// Build option:
//   RX_MAJORITY_EN  when defined, every bit decision is the majority of the
//                   last three synchronized samples; latency is unchanged.
module rx_ten_eight #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    rx_ten_eight_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [19:0]            cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             sh_q, sh_d;
    logic [7:0]             dout_q, dout_d;
    logic [9:0]             rxd_q, rxd_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   arm_q, arm_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic                   rx_s;
    logic                   bit_val;
    logic [19:0]            half;
    logic [19:0]            start_pt;
    logic [19:0]            bit_pt;
    logic                   baud_ok;

    // ------------------------------------------------------------------
    // Input synchronizer; flops reset to the idle line level.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx_in};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef RX_MAJORITY_EN
    // Two previous rx_s values; with the current one they form the
    // three-sample voting window ending on the decision cycle.
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '1;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign bit_val = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign bit_val = rx_s;
`endif

    // ------------------------------------------------------------------
    // Bit timing points.
    // The falling edge is recognised in IDLE one cycle before START is
    // entered, so the start-bit check falls at cnt == half-1: exactly half
    // a bit after detection, which keeps every later sample mid-bit.
    // ------------------------------------------------------------------
    assign half     = bus.baud >> 1;
    assign start_pt = half - 20'd1;
    assign bit_pt   = bus.baud - 20'd1;
    assign baud_ok  = (bus.baud >= 20'd4);

    // ------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            rxd_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            arm_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            rxd_q   <= rxd_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            arm_q   <= arm_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic.
    // arm_q blocks a new start after a framing error until the line has
    // been seen high in IDLE, so a held-low (break) line does not produce
    // a stream of error frames.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        rxd_d   = rxd_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        arm_d   = arm_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_s) begin
                    arm_d = 1'b1;
                end
                if (bus.en && baud_ok && !rx_s && arm_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == start_pt) begin
                    cnt_d = '0;
                    if (!bit_val) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            DATA: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == bit_pt) begin
                    cnt_d = '0;
                    sh_d  = {bit_val, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            STOP: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == bit_pt) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    rxd_d   = {bit_val, sh_q, 1'b0};
                    if (bit_val) begin
                        dout_d  = sh_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        arm_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign bus.dout      = dout_q;
    assign bus.rx_d      = rxd_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = err_q;
    assign bus.rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_rx_ten_eight.sv
// tb_rx_ten_eight - directed, scoreboard-checked bench for rx_ten_eight.
module tb_rx_ten_eight;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rx_ten_eight_if bus ();

    rx_ten_eight #(.SYNC_STAGES(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] dout;
        logic [9:0] rx_d;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    int         n_err = 0;
    int         baud_i = 8;
    logic [7:0] exp_dout = 8'h00;
    logic [9:0] exp_rxd = 10'h000;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every strobe.
    logic prev_strobe = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (prev_strobe) begin
            check("strobe_width", {30'd0, bus.rx_valid, bus.frame_err}, 32'd0);
        end
        prev_strobe = 1'b0;
        if (bus.rx_valid === 1'b1 || bus.frame_err === 1'b1) begin
            prev_strobe = 1'b1;
            if (bus.rx_valid === 1'b1) n_valid++;
            if (bus.frame_err === 1'b1) n_err++;
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, bus.rx_valid, bus.frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind", {30'd0, bus.rx_valid, bus.frame_err},
                      e.is_err ? 32'd1 : 32'd2);
                check("dout", {24'd0, bus.dout}, {24'd0, e.dout});
                check("rx_d", {22'd0, bus.rx_d}, {22'd0, e.rx_d});
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_baud(input int b);
        baud_i   = b;
        bus.baud = 20'(b);
    endtask

    // Sends one frame; glitch_k >= 0 forces rx_in low before that edge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int glitch_k, input logic [7:0] exp_byte);
        logic [9:0] frame;
        exp_t       e;
        int         e0;
        frame    = {stop_bit, data, 1'b0};
        e0       = cyc + 1;
        e.is_err = !stop_bit;
        e.rx_d   = {stop_bit, exp_byte, 1'b0};
        e.dout   = stop_bit ? exp_byte : exp_dout;
        e.cyc    = e0 + SYNC + (baud_i / 2) + 9 * baud_i;
        sb.push_back(e);
        exp_dout = e.dout;
        exp_rxd  = e.rx_d;
        for (int k = 0; k < 10 * baud_i; k++) begin
            bus.rx_in = (k == glitch_k) ? 1'b0 : frame[k / baud_i];
            @(posedge clk);
            #1;
        end
        bus.rx_in = 1'b1;
    endtask

    // Starts a frame and aborts it with rst (use_rst) or en=0 at edge k_abort.
    task automatic abort_frame(input logic [7:0] data, input int k_abort, input logic use_rst);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int k = 0; k <= k_abort; k++) begin
            bus.rx_in = frame[k / baud_i];
            if (k == k_abort) begin
                if (use_rst) rst = 1'b1;
                else bus.en = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check(use_rst ? "rst_abort_busy" : "en_abort_busy", {31'd0, bus.rx_busy}, 32'd0);
        if (use_rst) begin
            exp_dout = 8'h00;
            exp_rxd  = 10'h000;
            check("rst_abort_valid", {31'd0, bus.rx_valid}, 32'd0);
            check("rst_abort_err", {31'd0, bus.frame_err}, 32'd0);
        end
        check(use_rst ? "rst_abort_dout" : "en_abort_dout", {24'd0, bus.dout}, {24'd0, exp_dout});
        check(use_rst ? "rst_abort_rxd" : "en_abort_rxd", {22'd0, bus.rx_d}, {22'd0, exp_rxd});
        rst       = 1'b0;
        bus.en    = 1'b1;
        bus.rx_in = 1'b1;
    endtask

    initial begin
        logic [7:0] glitch_exp;

        bus.en    = 1'b1;
        bus.rx_in = 1'b1;
        set_baud(8);

        // Reset state
        rst = 1'b1;
        tick(3);
        check("reset_dout", {24'd0, bus.dout}, 32'd0);
        check("reset_rxd", {22'd0, bus.rx_d}, 32'd0);
        check("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("reset_err", {31'd0, bus.frame_err}, 32'd0);
        check("reset_busy", {31'd0, bus.rx_busy}, 32'd0);
        rst = 1'b0;
        tick(5);

        // Good frame
        send_frame(8'hA5, 1'b1, -1, 8'hA5);
        tick(10);
        check("good_dout", {24'd0, bus.dout}, 32'h0000_00A5);
        check("good_rxd", {22'd0, bus.rx_d}, 32'h0000_034A);

        // Framing error
        send_frame(8'h3C, 1'b0, -1, 8'h3C);
        bus.rx_in = 1'b1;
        tick(10);
        check("ferr_dout", {24'd0, bus.dout}, 32'h0000_00A5);
        check("ferr_rxd", {22'd0, bus.rx_d}, 32'h0000_0078);

        // False start at baud 16, then a good frame
        set_baud(16);
        for (int k = 0; k < 14; k++) begin
            bus.rx_in = (k < 3) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (k == 5) check("false_start_busy_hi", {31'd0, bus.rx_busy}, 32'd1);
            if (k == 10) check("false_start_busy_lo", {31'd0, bus.rx_busy}, 32'd0);
        end
        tick(20);
        send_frame(8'h55, 1'b1, -1, 8'h55);
        tick(10);
        check("after_false_dout", {24'd0, bus.dout}, 32'h0000_0055);

        // Back-to-back at baud 10
        set_baud(10);
        send_frame(8'h00, 1'b1, -1, 8'h00);
        send_frame(8'hFF, 1'b1, -1, 8'hFF);
        tick(10);
        check("b2b_dout", {24'd0, bus.dout}, 32'h0000_00FF);

        // Reset abort at data bit 4, then enable abort after a good frame
        set_baud(8);
        abort_frame(8'h96, 5 * 8 + 2, 1'b1);
        tick(40);
        send_frame(8'h5A, 1'b1, -1, 8'h5A);
        tick(10);
        abort_frame(8'h81, 5 * 8 + 2, 1'b0);
        tick(40);
        check("en_abort_dout_later", {24'd0, bus.dout}, 32'h0000_005A);

        // Glitch on data bit 5 sample point
        set_baud(16);
`ifdef RX_MAJORITY_EN
        glitch_exp = 8'hF0;
`else
        glitch_exp = 8'hD0;
`endif
        send_frame(8'hF0, 1'b1, 8 + 6 * 16, glitch_exp);
        tick(10);
        check("glitch_dout", {24'd0, bus.dout}, {24'd0, glitch_exp});

        // Break: line held low, one error then no restart until high
        set_baud(8);
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.dout   = exp_dout;
            e.rx_d   = 10'h000;
            e.cyc    = cyc + 1 + SYNC + 4 + 72;
            sb.push_back(e);
            exp_rxd = 10'h000;
        end
        bus.rx_in = 1'b0;
        tick(12 * 8);
        check("break_busy", {31'd0, bus.rx_busy}, 32'd0);
        bus.rx_in = 1'b1;
        tick(10);
        send_frame(8'hC3, 1'b1, -1, 8'hC3);
        tick(20);
        check("break_recover_dout", {24'd0, bus.dout}, 32'h0000_00C3);

        // Final bookkeeping
        check("scoreboard_empty", sb.size(), 32'd0);
        check("valid_count", n_valid, 32'd7);
        check("err_count", n_err, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
